// File: rtl/keypad_pkg.sv
// Shared types for the keypad operand entry block: key classes, command key
// positions and the entry FSM state encoding.
package keypad_pkg;

    typedef enum logic [2:0] {
        KEY_DIGIT,
        KEY_CLEAR,
        KEY_ENTER,
        KEY_SIGN,
        KEY_NONE
    } key_class_e;

    localparam logic [3:0] POS_STAR = 4'd3;
    localparam logic [3:0] POS_HASH = 4'd11;
    localparam logic [3:0] POS_A    = 4'd12;

    typedef enum logic [1:0] {
        StIdle,
        StEntry,
        StHold
    } state_e;

endpackage

// File: rtl/keypad_key_decode.sv
// Combinational map from keypad position {col,row} to key class and digit value.
module keypad_key_decode
    import keypad_pkg::*;
(
    input  logic [3:0] pos,
    output key_class_e key_class,
    output logic [3:0] digit
);

    always_comb begin
        key_class = KEY_DIGIT;
        digit     = 4'd0;
        case (pos)
            4'd0:     digit = 4'd1;
            4'd1:     digit = 4'd4;
            4'd2:     digit = 4'd7;
            4'd4:     digit = 4'd2;
            4'd5:     digit = 4'd5;
            4'd6:     digit = 4'd8;
            4'd7:     digit = 4'd0;
            4'd8:     digit = 4'd3;
            4'd9:     digit = 4'd6;
            4'd10:    digit = 4'd9;
            POS_STAR: key_class = KEY_CLEAR;
            POS_HASH: key_class = KEY_ENTER;
            POS_A:    key_class = KEY_SIGN;
            default:  key_class = KEY_NONE;
        endcase
    end

endmodule

// File: rtl/keypad_operand_entry.sv
// Multi-digit signed decimal operand entry from keypad events, presented with a
// valid/ack handshake. Define KEYPAD_BCD_OUT_EN to add the bcd_o digit register.
module keypad_operand_entry
    import keypad_pkg::*;
#(
    parameter int unsigned N_DIGITS = 3,
    parameter int unsigned OUT_W    = 10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              key_valid_i,
    input  logic [1:0]                        key_col_i,
    input  logic [1:0]                        key_row_i,
    input  logic                              operand_ack_i,
    output logic [OUT_W-1:0]                  operand_o,
    output logic                              neg_o,
    output logic [$clog2(N_DIGITS+1)-1:0]     digits_o,
    output logic                              operand_valid_o,
    output logic                              err_o
`ifdef KEYPAD_BCD_OUT_EN
    ,
    output logic [N_DIGITS*4-1:0]             bcd_o
`endif
);

    localparam int unsigned DigW = $clog2(N_DIGITS + 1);
    localparam logic [DigW-1:0] MaxDigits = DigW'(N_DIGITS);
    localparam logic [DigW-1:0] OneDigit  = DigW'(1);

    key_class_e          key_class;
    logic [3:0]          digit;
    state_e              state_q, state_d;
    logic [OUT_W-1:0]    operand_d;
    logic                neg_d;
    logic [DigW-1:0]     digits_d;
    logic                valid_d;
    logic                err_d;
    logic                clear;
`ifdef KEYPAD_BCD_OUT_EN
    localparam int unsigned BcdW = N_DIGITS * 4;
    logic [BcdW-1:0]     bcd_d;
`endif

    keypad_key_decode u_decode (
        .pos       ({key_col_i, key_row_i}),
        .key_class (key_class),
        .digit     (digit)
    );

    always_comb begin
        state_d   = state_q;
        operand_d = operand_o;
        neg_d     = neg_o;
        digits_d  = digits_o;
        valid_d   = operand_valid_o;
        err_d     = 1'b0;
        clear     = 1'b0;
`ifdef KEYPAD_BCD_OUT_EN
        bcd_d     = bcd_o;
`endif
        case (state_q)
            StHold: begin
                // Only CLEAR or the downstream ack can leave HOLD; other keys are dropped.
                if (operand_ack_i || (key_valid_i && key_class == KEY_CLEAR)) begin
                    clear = 1'b1;
                end
            end
            default: begin
                if (key_valid_i) begin
                    case (key_class)
                        KEY_DIGIT: begin
                            if (digits_o < MaxDigits) begin
                                operand_d = (operand_o << 3) + (operand_o << 1) + OUT_W'(digit);
                                digits_d  = digits_o + OneDigit;
                                state_d   = StEntry;
`ifdef KEYPAD_BCD_OUT_EN
                                bcd_d     = (bcd_o << 4) | BcdW'(digit);
`endif
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        KEY_SIGN: begin
                            neg_d   = ~neg_o;
                            state_d = StEntry;
                        end
                        KEY_ENTER: begin
                            if (digits_o != '0) begin
                                state_d = StHold;
                                valid_d = 1'b1;
                                if (operand_o == '0) begin
                                    neg_d = 1'b0;
                                end
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        KEY_CLEAR: clear = 1'b1;
                        default: ;
                    endcase
                end
            end
        endcase

        if (clear) begin
            state_d   = StIdle;
            operand_d = '0;
            neg_d     = 1'b0;
            digits_d  = '0;
            valid_d   = 1'b0;
`ifdef KEYPAD_BCD_OUT_EN
            bcd_d     = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= StIdle;
            operand_o       <= '0;
            neg_o           <= 1'b0;
            digits_o        <= '0;
            operand_valid_o <= 1'b0;
            err_o           <= 1'b0;
`ifdef KEYPAD_BCD_OUT_EN
            bcd_o           <= '0;
`endif
        end else begin
            state_q         <= state_d;
            operand_o       <= operand_d;
            neg_o           <= neg_d;
            digits_o        <= digits_d;
            operand_valid_o <= valid_d;
            err_o           <= err_d;
`ifdef KEYPAD_BCD_OUT_EN
            bcd_o           <= bcd_d;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Scoreboard bench for keypad_operand_entry: directed key sequences followed by
// random traffic, checked every cycle against a keypad-face reference model.
module tb_keypad_operand_entry;

    localparam int N_DIGITS = 3;
    localparam int OUT_W    = 10;
    localparam int DIG_W    = $clog2(N_DIGITS + 1);
    localparam int BCD_W    = N_DIGITS * 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                key_valid_i = 1'b0;
    logic [1:0]          key_col_i = 2'd0;
    logic [1:0]          key_row_i = 2'd0;
    logic                operand_ack_i = 1'b0;
    logic [OUT_W-1:0]    operand_o;
    logic                neg_o;
    logic [DIG_W-1:0]    digits_o;
    logic                operand_valid_o;
    logic                err_o;
`ifdef KEYPAD_BCD_OUT_EN
    logic [BCD_W-1:0]    bcd_o;
`endif

    keypad_operand_entry #(
        .N_DIGITS (N_DIGITS),
        .OUT_W    (OUT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .key_valid_i     (key_valid_i),
        .key_col_i       (key_col_i),
        .key_row_i       (key_row_i),
        .operand_ack_i   (operand_ack_i),
        .operand_o       (operand_o),
        .neg_o           (neg_o),
        .digits_o        (digits_o),
        .operand_valid_o (operand_valid_o),
        .err_o           (err_o)
`ifdef KEYPAD_BCD_OUT_EN
        ,
        .bcd_o           (bcd_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        longint operand;
        bit     neg;
        int     digits;
        bit     valid;
        bit     err;
        longint bcd;
    } snap_t;

    snap_t sb[$];
    int checks   = 0;
    int failures = 0;

    // Reference model: the keypad face as printed, digits kept as a list.
    string labels = "147*2580369#ABCD";
    int    m_digits[$];
    bit    m_neg, m_hold, m_err;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.operand = 0;
        s.bcd     = 0;
        foreach (m_digits[i]) begin
            s.operand = s.operand * 10 + m_digits[i];
            s.bcd     = (s.bcd << 4) | longint'(m_digits[i]);
        end
        s.neg    = m_neg;
        s.digits = m_digits.size();
        s.valid  = m_hold;
        s.err    = m_err;
        return s;
    endfunction

    function automatic void model_clear();
        m_digits.delete();
        m_neg  = 1'b0;
        m_hold = 1'b0;
    endfunction

    function automatic void model_step(input bit kv, input int pos, input bit ack, input bit r);
        byte   c;
        snap_t cur;
        c     = labels[pos];
        m_err = 1'b0;
        if (!r) begin
            model_clear();
        end else if (m_hold) begin
            if (ack || (kv && c == "*")) model_clear();
        end else if (kv) begin
            if (c >= 8'd48 && c <= 8'd57) begin
                if (m_digits.size() < N_DIGITS) m_digits.push_back(int'(c) - 48);
                else m_err = 1'b1;
            end else if (c == "*") begin
                model_clear();
            end else if (c == "A") begin
                m_neg = ~m_neg;
            end else if (c == "#") begin
                cur = model_snap();
                if (m_digits.size() > 0) begin
                    m_hold = 1'b1;
                    if (cur.operand == 0) m_neg = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endfunction

    task automatic step(input bit kv, input int pos, input bit ack, input bit r);
        @(negedge clk);
        key_valid_i   = kv;
        key_col_i     = pos[3:2];
        key_row_i     = pos[1:0];
        operand_ack_i = ack;
        rst           = r;
        model_step(kv, pos, ack, r);
        sb.push_back(model_snap());
    endtask

    task automatic key(input int pos);
        step(1'b1, pos, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b1);
    endtask

    // Monitor: one expected snapshot per cycle, compared just after the edge.
    always @(posedge clk) begin
        snap_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("operand", longint'(operand_o), e.operand);
            check("neg", longint'(neg_o), longint'(e.neg));
            check("digits", longint'(digits_o), longint'(e.digits));
            check("valid", longint'(operand_valid_o), longint'(e.valid));
            check("err", longint'(err_o), longint'(e.err));
`ifdef KEYPAD_BCD_OUT_EN
            check("bcd", longint'(bcd_o), e.bcd);
`endif
        end
    end

    int pool[14] = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 7, 11, 11, 12, 3};

    initial begin
        m_err = 1'b0;
        model_clear();
        step(1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
        idle(1);
        // 1,2,3 ENTER, then ack
        key(0); key(4); key(8); key(11); idle(2);
        step(1'b0, 0, 1'b1, 1'b1); idle(1);
        // SIGN 4 5 ENTER, ack
        key(12); key(1); key(5); key(11); idle(1);
        step(1'b0, 0, 1'b1, 1'b1); idle(1);
        // 9,9,9,7 overflow, CLEAR
        key(10); key(10); key(10); key(2); idle(1); key(3); idle(1);
        // ENTER with no digits; SIGN 0 ENTER gives +0
        key(11); idle(1); key(12); key(7); key(11); idle(1);
        step(1'b0, 0, 1'b1, 1'b1);
        // digit during HOLD, then CLEAR with ack together
        key(5); key(11); key(5); step(1'b1, 3, 1'b1, 1'b1); idle(1);
        // reset mid-entry
        key(9); key(2); step(1'b0, 0, 1'b0, 1'b0); idle(1);
        key(0); key(4); key(8); idle(1); key(3);
        // random traffic
        for (int i = 0; i < 2000; i++) begin
            int p;
            if ($urandom_range(0, 1) == 0) p = int'($urandom_range(0, 15));
            else p = pool[$urandom_range(0, 13)];
            step(($urandom_range(0, 2) != 0), p, ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 99) != 0));
        end
        idle(2);
        repeat (2) @(posedge clk);
        #2;
        check("sb_drained", longint'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_operand_entry.md
# keypad_operand_entry

Parametrised multi-digit operand entry for the 4x4 matrix keypad. Consumes one decoded key event per `key_valid_i` pulse from the keypad scanner/debouncer, maps {column,row} to a digit or command, and accumulates a signed decimal operand of up to `N_DIGITS` digits in binary. A completed operand is presented with a valid/ack handshake to the downstream multiplier control.

## Interface
- `N_DIGITS`, default 3, maximum number of decimal digits accepted per operand (1..6).
- `OUT_W`, default 10, binary magnitude width; must satisfy 2^OUT_W > 10^N_DIGITS - 1.
- `clk`  input  1  system clock.
- `rst`  input  1  reset; synchronous, active-low.
- `key_valid_i`  input  1  one-cycle pulse, key code valid this cycle.
- `key_col_i`  input  2  column code of pressed key.
- `key_row_i`  input  2  row code of pressed key.
- `operand_ack_i`  input  1  downstream consumed the presented operand.
- `operand_o`  output  OUT_W  running or final magnitude, binary.
- `neg_o`  output  1  operand sign, 1 = negative.
- `digits_o`  output  $clog2(N_DIGITS+1)  digits entered so far.
- `operand_valid_o`  output  1  level; final operand held on outputs.
- `err_o`  output  1  one-cycle pulse on a rejected key.

## Operation
- Key position pos = {col,row}. Digits: 0→1, 1→4, 2→7, 4→2, 5→5, 6→8, 8→3, 9→6, 10→9, 7→0.
- Commands: 3 (`*`) = CLEAR, 11 (`#`) = ENTER, 12 (`A`) = SIGN toggle. 13, 14, 15 ignored, no error.
- FSM states: IDLE (nothing entered), ENTRY (≥1 digit or sign pressed), HOLD (operand presented).
- IDLE/ENTRY, digit with digits_o < N_DIGITS: operand_o ← operand_o*10 + d (computed as (x<<3)+(x<<1)+d, OUT_W bits, no overflow by parameter rule); digits_o +1; state → ENTRY.
- Digit with digits_o = N_DIGITS: ignored, err_o pulse.
- SIGN: neg_o toggles; IDLE → ENTRY.
- ENTER with digits_o ≥ 1: → HOLD, operand_valid_o = 1; if magnitude is 0, neg_o forced 0.
- ENTER with digits_o = 0: ignored, err_o pulse, state unchanged.
- CLEAR in any state: operand_o, neg_o, digits_o ← 0, operand_valid_o ← 0, → IDLE.
- HOLD: all keys except CLEAR ignored (no error). operand_ack_i → IDLE, all outputs cleared.
- CLEAR and ack in same cycle: → IDLE (identical result).
- operand_ack_i outside HOLD: ignored.

## Timing
- Reset (rst = 0 at clk edge): state IDLE; operand_o, neg_o, digits_o, operand_valid_o, err_o all 0. Reset mid-entry or during HOLD discards the operand.
- All outputs registered; latency 1 cycle from `key_valid_i` to updated operand_o/digits_o/neg_o.
- operand_valid_o rises 1 cycle after ENTER pulse; falls 1 cycle after ack sampled.
- err_o high exactly 1 cycle, the cycle after the offending key.
- Back-to-back key pulses on consecutive cycles each processed.

## Configuration
- `KEYPAD_BCD_OUT_EN` defined: extra output `bcd_o` (N_DIGITS*4 bits), BCD shift register updated alongside operand_o (new digit shifted into least-significant nibble), cleared with the operand, reset 0.
- Not defined: no `bcd_o` port, no BCD register; binary behaviour identical.

## Structure
- Package `keypad_pkg`: key class enum (KEY_DIGIT, KEY_CLEAR, KEY_ENTER, KEY_SIGN, KEY_NONE), position constants for `*`, `#`, `A`, FSM state enum.
- Sub-module `keypad_key_decode`: combinational pos → {class, digit[3:0]}.

## Test plan
- Reset, then keys 1,2,3 (pos 0,4,8), ENTER → operand_o=123, neg_o=0, digits_o=3, operand_valid_o=1 one cycle after ENTER.
- SIGN, 4, 5, ENTER → operand_o=45, neg_o=1; ack → all outputs 0, IDLE.
- N_DIGITS=3: 9,9,9,7 → fourth key gives err_o pulse, operand_o stays 999.
- ENTER with no digits → err_o pulse, operand_valid_o stays 0; SIGN, 0, ENTER → operand_o=0, neg_o=0.
- During HOLD press 5 then CLEAR with ack same cycle → digit ignored, then IDLE, outputs 0.
- Assert rst after 6,7 entered → next cycle operand_o=0, digits_o=0; with `KEYPAD_BCD_OUT_EN`, 1,2,3 → bcd_o=12'h123.
